// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one line-wide memory port between the Icache miss path and the Dcache
// refill/writeback path. Each cache sends a one-cycle request pulse. The pulse is
// latched as pending, and one requester at a time is granted. The grant goes to
// memory as a one-cycle valid pulse. The 128-bit response comes back to the
// granted cache as a one-cycle ready pulse.
//
// An Icache flush (ic_cancel_i) drops a pending Icache request. It also marks an
// in-flight Icache transaction for discard. A watchdog aborts any transaction
// that sees no mem_ready_i within TIMEOUT_CYC busy cycles.
//
// Parameters
//   ARB_MODE     0 = fixed priority (Dcache wins ties), 1 = round-robin
//   TIMEOUT_CYC  busy cycles without mem_ready_i before abort (1..255)
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   ic_addr_i / ic_valid_req_i       Icache line address and request pulse
//   ic_cancel_i                      Icache flush
//   ic_ready_o / ic_data_o           Icache response pulse and held line data
//   dc_addr_i / dc_valid_req_i       Dcache line address and request pulse
//   dc_we_i / dc_wdata_i             Dcache write enable and write line
//   dc_ready_o / dc_data_o           Dcache completion pulse and held read data
//   mem_addr_o / mem_valid_req_o     memory address (16-byte aligned) and request pulse
//   mem_we_o / mem_wdata_o           memory write enable and write data
//   mem_ready_i / mem_data_i         memory completion pulse and read data
//   err_timeout_o                    sticky watchdog flag
module mem_port_arbiter #(
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic [31:0]  ic_addr_i,
    input  logic         ic_valid_req_i,
    input  logic         ic_cancel_i,
    output logic         ic_ready_o,
    output logic [127:0] ic_data_o,

    input  logic [31:0]  dc_addr_i,
    input  logic         dc_valid_req_i,
    input  logic         dc_we_i,
    input  logic [127:0] dc_wdata_i,
    output logic         dc_ready_o,
    output logic [127:0] dc_data_o,

    output logic [31:0]  mem_addr_o,
    output logic         mem_valid_req_o,
    output logic         mem_we_o,
    output logic [127:0] mem_wdata_o,
    input  logic         mem_ready_i,
    input  logic [127:0] mem_data_i,

    output logic         err_timeout_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;
    typedef enum logic [0:0] {GrantIc, GrantDc} grant_e;

    localparam logic [31:0] LineMask = 32'hFFFF_FFF0;

    state_e        state_q;
    grant_e        grant_q;
    grant_e        last_grant_q;
    logic          ic_pend_q;
    logic          dc_pend_q;
    logic          discard_q;
    logic [31:0]   ic_addr_q;
    logic [31:0]   dc_addr_q;
    logic          dc_we_q;
    logic [127:0]  dc_wdata_q;
    logic [7:0]    cnt_q;

    // A pulse arriving this cycle supersedes the captured copy, so a request can
    // be issued at the very edge that samples it.
    logic [31:0]   ic_addr_eff;
    logic [31:0]   dc_addr_eff;
    logic          dc_we_eff;
    logic [127:0]  dc_wdata_eff;
    logic          ic_cand;
    logic          dc_cand;
    logic          pick_dc;
    logic [7:0]    cnt_inc;
    logic [7:0]    timeout_val;
    logic          time_out;
    logic          mem_done;
    logic          ic_drop;
    logic [127:0]  resp_data;

    assign timeout_val = TIMEOUT_CYC[7:0];

    always_comb begin
        ic_addr_eff  = ic_valid_req_i ? (ic_addr_i & LineMask) : ic_addr_q;
        dc_addr_eff  = dc_valid_req_i ? (dc_addr_i & LineMask) : dc_addr_q;
        dc_we_eff    = dc_valid_req_i ? dc_we_i : dc_we_q;
        dc_wdata_eff = dc_valid_req_i ? dc_wdata_i : dc_wdata_q;

        // A cancel kills a registered Icache request, but a fresh pulse in the
        // same cycle survives it.
        ic_cand = (ic_pend_q & ~ic_cancel_i) | ic_valid_req_i;
        dc_cand = dc_pend_q | dc_valid_req_i;

        if (ic_cand && dc_cand) begin
            if (ARB_MODE == 0) begin
                pick_dc = 1'b1;
            end else begin
                pick_dc = (last_grant_q == GrantIc);
            end
        end else begin
            pick_dc = dc_cand;
        end

        cnt_inc   = cnt_q + 8'd1;
        time_out  = ~mem_ready_i & (cnt_inc == timeout_val);
        mem_done  = mem_ready_i | time_out;
        // A cancel that lands on the completion cycle still suppresses delivery.
        ic_drop   = discard_q | ic_cancel_i;
        resp_data = mem_ready_i ? mem_data_i : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            grant_q         <= GrantIc;
            last_grant_q    <= GrantIc;
            ic_pend_q       <= 1'b0;
            dc_pend_q       <= 1'b0;
            discard_q       <= 1'b0;
            ic_addr_q       <= '0;
            dc_addr_q       <= '0;
            dc_we_q         <= 1'b0;
            dc_wdata_q      <= '0;
            cnt_q           <= '0;
            ic_ready_o      <= 1'b0;
            ic_data_o       <= '0;
            dc_ready_o      <= 1'b0;
            dc_data_o       <= '0;
            mem_addr_o      <= '0;
            mem_valid_req_o <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_wdata_o     <= '0;
            err_timeout_o   <= 1'b0;
        end else begin
            ic_ready_o      <= 1'b0;
            dc_ready_o      <= 1'b0;
            mem_valid_req_o <= 1'b0;

            // Request capture runs in every state; a grant below overrides the
            // pending flag of the winner.
            if (ic_valid_req_i) begin
                ic_pend_q <= 1'b1;
                ic_addr_q <= ic_addr_eff;
            end else if (ic_cancel_i) begin
                ic_pend_q <= 1'b0;
            end
            if (dc_valid_req_i) begin
                dc_pend_q  <= 1'b1;
                dc_addr_q  <= dc_addr_eff;
                dc_we_q    <= dc_we_eff;
                dc_wdata_q <= dc_wdata_eff;
            end

            unique case (state_q)
                StIdle: begin
                    if (ic_cand || dc_cand) begin
                        mem_valid_req_o <= 1'b1;
                        cnt_q           <= '0;
                        state_q         <= StBusy;
                        if (pick_dc) begin
                            mem_addr_o   <= dc_addr_eff;
                            mem_we_o     <= dc_we_eff;
                            mem_wdata_o  <= dc_wdata_eff;
                            dc_pend_q    <= 1'b0;
                            grant_q      <= GrantDc;
                            last_grant_q <= GrantDc;
                        end else begin
                            // Icache only reads; drive zeros on the write bus.
                            mem_addr_o   <= ic_addr_eff;
                            mem_we_o     <= 1'b0;
                            mem_wdata_o  <= '0;
                            ic_pend_q    <= 1'b0;
                            grant_q      <= GrantIc;
                            last_grant_q <= GrantIc;
                        end
                    end
                end

                StBusy: begin
                    cnt_q <= cnt_inc;
                    if (grant_q == GrantIc && ic_cancel_i) begin
                        discard_q <= 1'b1;
                    end
                    if (mem_done) begin
                        state_q   <= StIdle;
                        discard_q <= 1'b0;
                        if (time_out) begin
                            err_timeout_o <= 1'b1;
                        end
                        if (grant_q == GrantDc) begin
                            dc_ready_o <= 1'b1;
                            dc_data_o  <= resp_data;
                        end else if (!ic_drop) begin
                            ic_ready_o <= 1'b1;
                            ic_data_o  <= resp_data;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0]  ic_addr, dc_addr;
    logic         ic_valid, ic_cancel, dc_valid, dc_we, mem_ready;
    logic [127:0] dc_wdata, mem_data;

    // Index 0: fixed priority, index 1: round-robin.
    logic [1:0]         icr, dcr, mv, mwe, err;
    logic [1:0][127:0]  icd, dcd, mwd;
    logic [1:0][31:0]   ma;

    mem_port_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(TO)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .ic_addr_i(ic_addr), .ic_valid_req_i(ic_valid), .ic_cancel_i(ic_cancel),
        .ic_ready_o(icr[0]), .ic_data_o(icd[0]),
        .dc_addr_i(dc_addr), .dc_valid_req_i(dc_valid), .dc_we_i(dc_we),
        .dc_wdata_i(dc_wdata), .dc_ready_o(dcr[0]), .dc_data_o(dcd[0]),
        .mem_addr_o(ma[0]), .mem_valid_req_o(mv[0]), .mem_we_o(mwe[0]),
        .mem_wdata_o(mwd[0]), .mem_ready_i(mem_ready), .mem_data_i(mem_data),
        .err_timeout_o(err[0])
    );

    mem_port_arbiter #(.ARB_MODE(1), .TIMEOUT_CYC(TO)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .ic_addr_i(ic_addr), .ic_valid_req_i(ic_valid), .ic_cancel_i(ic_cancel),
        .ic_ready_o(icr[1]), .ic_data_o(icd[1]),
        .dc_addr_i(dc_addr), .dc_valid_req_i(dc_valid), .dc_we_i(dc_we),
        .dc_wdata_i(dc_wdata), .dc_ready_o(dcr[1]), .dc_data_o(dcd[1]),
        .mem_addr_o(ma[1]), .mem_valid_req_o(mv[1]), .mem_we_o(mwe[1]),
        .mem_wdata_o(mwd[1]), .mem_ready_i(mem_ready), .mem_data_i(mem_data),
        .err_timeout_o(err[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Requester 0 = Icache, 1 = Dcache.
    bit           m_busy [2];
    int           m_who  [2];
    int           m_last [2];
    int           m_age  [2];
    bit           m_disc [2];
    bit           m_pend [2][2];
    logic [31:0]  m_addr [2][2];
    bit           m_we   [2];
    logic [127:0] m_wd   [2];

    logic         e_mv [2], e_mwe [2], e_icr [2], e_dcr [2], e_err [2];
    logic [31:0]  e_ma [2];
    logic [127:0] e_mwd [2], e_icd [2], e_dcd [2];

    task automatic mreset(input int k);
        m_busy[k] = 0; m_who[k] = 0; m_last[k] = 0; m_age[k] = 0; m_disc[k] = 0;
        m_we[k] = 0; m_wd[k] = '0;
        for (int r = 0; r < 2; r++) begin
            m_pend[k][r] = 0;
            m_addr[k][r] = '0;
        end
        e_mv[k] = 0; e_mwe[k] = 0; e_icr[k] = 0; e_dcr[k] = 0; e_err[k] = 0;
        e_ma[k] = '0; e_mwd[k] = '0; e_icd[k] = '0; e_dcd[k] = '0;
    endtask

    task automatic mstep(input int k);
        bit           was_busy;
        bit           req [2];
        logic [31:0]  a_in [2];
        logic [127:0] d;
        int           w;
        was_busy = m_busy[k];
        req[0] = ic_valid;  a_in[0] = ic_addr;
        req[1] = dc_valid;  a_in[1] = dc_addr;
        e_icr[k] = 0; e_dcr[k] = 0; e_mv[k] = 0;

        if (m_busy[k]) begin
            m_age[k]++;
            if (mem_ready || m_age[k] == int'(TO)) begin
                d = mem_ready ? mem_data : '0;
                if (!mem_ready) e_err[k] = 1;
                if (m_who[k] == 1) begin
                    e_dcr[k] = 1; e_dcd[k] = d;
                end else if (!(m_disc[k] || ic_cancel)) begin
                    e_icr[k] = 1; e_icd[k] = d;
                end
                m_busy[k] = 0;
                m_disc[k] = 0;
            end else if (m_who[k] == 0 && ic_cancel) begin
                m_disc[k] = 1;
            end
        end

        if (ic_cancel) m_pend[k][0] = 0;
        for (int r = 0; r < 2; r++) begin
            if (req[r]) begin
                m_pend[k][r] = 1;
                m_addr[k][r] = a_in[r] & ~32'hF;
            end
        end
        if (req[1]) begin
            m_we[k] = dc_we;
            m_wd[k] = dc_wdata;
        end

        if (!was_busy) begin
            w = -1;
            if (m_pend[k][0] && m_pend[k][1]) w = (k == 0) ? 1 : 1 - m_last[k];
            else if (m_pend[k][1]) w = 1;
            else if (m_pend[k][0]) w = 0;
            if (w >= 0) begin
                m_pend[k][w] = 0;
                m_busy[k] = 1; m_who[k] = w; m_last[k] = w; m_age[k] = 0;
                e_mv[k]  = 1;
                e_ma[k]  = m_addr[k][w];
                e_mwe[k] = (w == 1) ? m_we[k] : 1'b0;
                e_mwd[k] = (w == 1) ? m_wd[k] : '0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) mreset(k);
        end else begin
            for (int k = 0; k < 2; k++) mstep(k);
        end
    end

    // Per-cycle comparison at mid-cycle against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d.mem_valid", k), 128'(mv[k]),  128'(e_mv[k]));
            check($sformatf("dut%0d.mem_addr",  k), 128'(ma[k]),  128'(e_ma[k]));
            check($sformatf("dut%0d.mem_we",    k), 128'(mwe[k]), 128'(e_mwe[k]));
            check($sformatf("dut%0d.mem_wdata", k), mwd[k], e_mwd[k]);
            check($sformatf("dut%0d.ic_ready",  k), 128'(icr[k]), 128'(e_icr[k]));
            check($sformatf("dut%0d.ic_data",   k), icd[k], e_icd[k]);
            check($sformatf("dut%0d.dc_ready",  k), 128'(dcr[k]), 128'(e_dcr[k]));
            check($sformatf("dut%0d.dc_data",   k), dcd[k], e_dcd[k]);
            check($sformatf("dut%0d.err",       k), 128'(err[k]), 128'(e_err[k]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        ic_valid  = 0;
        dc_valid  = 0;
        ic_cancel = 0;
        mem_ready = 0;
    endtask

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] DW  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D55 = {16{8'h55}};
    localparam logic [127:0] D1  = {16{8'h11}};
    localparam logic [127:0] D2  = {16{8'h22}};
    localparam logic [127:0] D3  = {16{8'h33}};
    localparam logic [127:0] D4  = {16{8'h44}};

    initial begin
        rst_n = 0;
        ic_addr = '0; dc_addr = '0; ic_valid = 0; ic_cancel = 0; dc_valid = 0;
        dc_we = 0; dc_wdata = '0; mem_ready = 0; mem_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.mem_valid", 128'(mv[0]), 128'(0));
        check("reset.mem_addr",  128'(ma[0]), 128'(0));
        check("reset.ic_ready",  128'(icr[0]), 128'(0));
        check("reset.err",       128'(err[0]), 128'(0));
        rst_n = 1;
        step(); step();

        // Lone Icache read
        ic_valid = 1; ic_addr = 32'h0000_1234;
        step();
        check("ic.mem_valid", 128'(mv[0]), 128'(1));
        check("ic.mem_addr",  128'(ma[0]), 128'(32'h0000_1230));
        check("ic.mem_we",    128'(mwe[0]), 128'(0));
        step(); step(); step();
        mem_ready = 1; mem_data = DA5;
        step();
        check("ic.ready",    128'(icr[0]), 128'(1));
        check("ic.data",     icd[0], DA5);
        check("ic.dc_ready", 128'(dcr[0]), 128'(0));
        step();
        check("ic.ready_one_cycle", 128'(icr[0]), 128'(0));

        // Dcache write
        step();
        dc_valid = 1; dc_we = 1; dc_wdata = DW; dc_addr = 32'h8000_0040;
        step();
        dc_we = 0;
        check("dcw.mem_we",    128'(mwe[0]), 128'(1));
        check("dcw.mem_wdata", mwd[0], DW);
        check("dcw.mem_addr",  128'(ma[0]), 128'(32'h8000_0040));
        step(); step();
        mem_ready = 1; mem_data = D55;
        step();
        check("dcw.ready0", 128'(dcr[0]), 128'(1));
        check("dcw.ready1", 128'(dcr[1]), 128'(1));
        check("dcw.data",   dcd[0], D55);
        step();

        // Simultaneous requests, last grant = Dcache
        step();
        ic_valid = 1; ic_addr = 32'h0000_4000;
        dc_valid = 1; dc_addr = 32'h0000_5004;
        step();
        check("tie.fixed_first", 128'(ma[0]), 128'(32'h0000_5000));
        check("tie.rr_first",    128'(ma[1]), 128'(32'h0000_4000));
        step();
        mem_ready = 1; mem_data = D1;
        step();
        check("tie.fixed_dc_ready", 128'(dcr[0]), 128'(1));
        check("tie.rr_ic_ready",    128'(icr[1]), 128'(1));
        check("tie.gap_idle",       128'(mv[0]), 128'(0));
        step();
        check("tie.fixed_second_valid", 128'(mv[0]), 128'(1));
        check("tie.fixed_second_addr",  128'(ma[0]), 128'(32'h0000_4000));
        check("tie.rr_second_addr",     128'(ma[1]), 128'(32'h0000_5000));
        mem_ready = 1; mem_data = D2;
        step();
        step();

        // Cancel in flight, then a new Icache request
        ic_valid = 1; ic_addr = 32'h0000_6000;
        step();
        step();
        ic_cancel = 1;
        step();
        ic_valid = 1; ic_addr = 32'h0000_7008;
        step(); step();
        mem_ready = 1; mem_data = {8{16'hBEEF}};
        step();
        check("cancel.no_ready", 128'(icr[0]), 128'(0));
        check("cancel.data_kept", icd[0], D2);
        check("cancel.idle", 128'(mv[0]), 128'(0));
        step();
        check("cancel.reissue_valid", 128'(mv[0]), 128'(1));
        check("cancel.reissue_addr",  128'(ma[0]), 128'(32'h0000_7000));
        mem_ready = 1; mem_data = D3;
        step();
        check("cancel.reissue_ready", 128'(icr[0]), 128'(1));
        check("cancel.reissue_data",  icd[0], D3);
        step();

        // Cancel while pending
        dc_valid = 1; dc_addr = 32'h0000_9000;
        step();
        ic_valid = 1; ic_addr = 32'h0000_A000;
        step();
        ic_cancel = 1;
        step();
        mem_ready = 1; mem_data = D4;
        step();
        check("pcancel.dc_ready", 128'(dcr[0]), 128'(1));
        check("pcancel.dc_data",  dcd[0], D4);
        for (int i = 0; i < 5; i++) begin
            step();
            check("pcancel.no_issue", 128'(mv[0] | mv[1]), 128'(0));
        end

        // Watchdog timeout
        dc_valid = 1; dc_addr = 32'h0000_B000;
        step();
        check("to.issue", 128'(mv[0]), 128'(1));
        repeat (7) step();
        check("to.not_yet_ready", 128'(dcr[0]), 128'(0));
        check("to.not_yet_err",   128'(err[0]), 128'(0));
        step();
        check("to.ready", 128'(dcr[0]), 128'(1));
        check("to.data",  dcd[0], 128'(0));
        check("to.err",   128'(err[0]), 128'(1));
        repeat (3) step();
        check("to.err_sticky", 128'(err[0]), 128'(1));

        // Reset mid-transaction
        ic_valid = 1; ic_addr = 32'h0000_C000;
        step();
        step();
        rst_n = 0;
        #1;
        check("rst.mem_valid", 128'(mv[0]), 128'(0));
        check("rst.mem_addr",  128'(ma[0]), 128'(0));
        check("rst.err",       128'(err[0]), 128'(0));
        check("rst.ic_data",   icd[0], 128'(0));
        step();
        rst_n = 1;
        step();

        // Sanity after reset
        ic_valid = 1; ic_addr = 32'h0000_D00F;
        step();
        check("post.mem_addr", 128'(ma[0]), 128'(32'h0000_D000));
        mem_ready = 1; mem_data = D1;
        step();
        check("post.ready_first_busy", 128'(icr[0]), 128'(1));
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single line-wide memory port between the Icache miss path and the Dcache refill/writeback path. Each cache issues a one-cycle request pulse. The arbiter latches each pulse, grants one requester at a time, and forwards the request to memory as a one-cycle valid pulse. It then routes the 128-bit response back as a one-cycle ready pulse. It also handles Icache cancellation on a jump/branch flush and a watchdog timeout on memory.

Parameters:
ARB_MODE, 0, 0 = fixed priority (Dcache wins ties), 1 = round-robin between Icache and Dcache
TIMEOUT_CYC, 255, maximum BUSY cycles without mem_ready_i before the transaction is aborted (8-bit counter, 1..255)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
ic_addr_i  in  32  Icache line address, sampled with ic_valid_req_i
ic_valid_req_i  in  1  Icache request pulse (one cycle)
ic_cancel_i  in  1  Icache flush (jump flag); drops the pending or in-flight Icache request
ic_ready_o  out  1  one-cycle pulse, ic_data_o valid
ic_data_o  out  128  Icache line data, held until next Icache response
dc_addr_i  in  32  Dcache line address
dc_valid_req_i  in  1  Dcache request pulse (one cycle)
dc_we_i  in  1  1 = line write, 0 = line read; sampled with the request
dc_wdata_i  in  128  write line data; sampled with the request
dc_ready_o  out  1  one-cycle pulse, Dcache transaction complete
dc_data_o  out  128  Dcache read data, held until next Dcache response
mem_addr_o  out  32  memory address, 16-byte aligned
mem_valid_req_o  out  1  one-cycle request pulse to memory
mem_we_o  out  1  write enable to memory
mem_wdata_o  out  128  write data to memory
mem_ready_i  in  1  memory completion pulse
mem_data_i  in  128  memory read data, valid with mem_ready_i
err_timeout_o  out  1  sticky flag, a memory transaction timed out

Behaviour:
- Reset: all outputs 0. State IDLE, pending flags 0, discard 0, last_grant = IC, counter 0.
- Request latching:
  - A request pulse sets the pending flag for that requester and captures its fields.
  - The address is stored with bits [3:0] forced to 0.
  - A pulse arriving while that requester is already pending or in flight overwrites the captured fields. Caches must not do this, except Icache after a cancel.
- ic_cancel_i:
  - Clears the Icache pending flag.
  - If the Icache is granted and in flight, sets discard.
  - If ic_cancel_i and ic_valid_req_i occur in the same cycle, the new request is latched as pending.
- States are IDLE and BUSY.
- IDLE:
  - Candidates are the registered pending flags OR the request pulses arriving this cycle. A request arriving in the same cycle as its cancel is still a candidate.
  - If any candidate exists, select one by ARB_MODE. In round-robin, a tie goes to the requester not equal to last_grant.
  - Register mem_addr_o, mem_we_o (0 for Icache) and mem_wdata_o, and set mem_valid_req_o = 1.
  - Clear the winner's pending flag, record grant and last_grant, clear the counter, go to BUSY.
  - Latency: request pulse in cycle T gives mem_valid_req_o high in cycle T+1 when memory is free.
- BUSY:
  - mem_valid_req_o returns to 0 after one cycle; mem_addr/we/wdata are held.
  - The counter increments each cycle.
  - mem_ready_i sampled high (including in the first BUSY cycle): copy mem_data_i to the granted data_o and pulse the granted ready_o next cycle. For Icache with discard = 1, there is no ready pulse and ic_data_o is unchanged. Clear discard, go to IDLE.
  - Counter reaching TIMEOUT_CYC without mem_ready_i: set err_timeout_o, pulse the granted ready_o with data_o = 0 (no Icache pulse if discard), go to IDLE.
- Back-to-back: the next grant happens at the edge after returning to IDLE, so there is at least one idle cycle between transactions on the mem port.
- mem_ready_i while IDLE is ignored.
- dc_data_o is updated on Dcache writes too (memory returns don't-care data).
- Reset mid-transaction abandons the transaction; memory is reset on the same rst_n.

Test Plan:
- Lone Icache read: ic_valid_req_i with ic_addr_i = 0x0000_1234 in cycle 0 -> mem_valid_req_o = 1, mem_addr_o = 0x0000_1230, mem_we_o = 0 in cycle 1. mem_ready_i with data 0xA5..A5 in cycle 4 -> ic_ready_o = 1 for exactly cycle 5, ic_data_o = 0xA5..A5, dc_ready_o stays 0.
- Simultaneous requests, ARB_MODE = 0: both pulse in cycle 0 -> Dcache issued first. Icache issued at the second edge after the Dcache mem_ready_i. ARB_MODE = 1 with last_grant = DC -> Icache issued first.
- Dcache write: dc_we_i = 1, dc_wdata_i = 0x0123..CDEF, dc_addr_i = 0x8000_0040 -> mem_we_o = 1 and mem_wdata_o equal to that data. dc_ready_o pulses one cycle after mem_ready_i.
- Cancel in flight: Icache request issued, ic_cancel_i in cycle 2, mem_ready_i in cycle 5 -> no ic_ready_o and ic_data_o unchanged. A new Icache request latched in cycle 3 is issued in cycle 7.
- Cancel while pending: Dcache in flight, Icache pends, ic_cancel_i -> Icache is never issued and mem_valid_req_o stays 0 after the Dcache completes.
- Timeout with TIMEOUT_CYC = 8 and no mem_ready_i -> granted ready_o pulses with data 0, err_timeout_o = 1 and stays 1 until rst_n. Asserting rst_n = 0 mid-BUSY clears every output to 0 immediately.
